// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate backed by a word-organised register memory.
// Programmable wait states, byte/half/word access, two-cycle ERROR for illegal transfers.
module ahb_sram_sub #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA
);
    localparam int         DEPTH  = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] LP_CNT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_hreadyout;
    logic                  r_hresp;
    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [1:0]            r_dp_size;
    logic [ADDR_WIDTH-1:0] r_dp_addr;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_complete;
    logic                  w_commit;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-3:0] w_waddr;
    wire                   w_unused_burst = ^HBURST;

    // Only sample a new address phase when our own previous data phase is not stalling.
    assign w_accept   = HSEL && HREADY && HTRANS[1] && r_hreadyout;
    assign w_illegal  = HSIZE[2] || (HSIZE[1:0] == 2'b11) ||
                        ((HSIZE[1:0] == 2'b01) && HADDR[0]) ||
                        ((HSIZE[1:0] == 2'b10) && (HADDR[1:0] != 2'b00));
    assign w_complete = (r_state == S_IDLE) && r_dp_valid && HREADY;
    assign w_commit   = w_complete && r_dp_write;
    assign w_waddr    = r_dp_addr[ADDR_WIDTH-1:2];

    always_comb begin
        w_be = 4'b0000;
        case (r_dp_size)
            2'd0:    w_be = 4'b0001 << r_dp_addr[1:0];
            2'd1:    w_be = r_dp_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_dp_size   <= 2'd0;
            r_dp_addr   <= '0;
        end else begin
            if (w_complete) r_dp_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR2: begin
                    if (r_state == S_ERR2) begin
                        r_state <= S_IDLE;
                        r_hresp <= 1'b0;
                    end
                    if (w_accept) begin
                        r_dp_write <= HWRITE;
                        r_dp_size  <= HSIZE[1:0];
                        r_dp_addr  <= HADDR;
                        if (w_illegal) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else begin
                            r_dp_valid <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                r_state     <= S_WAIT;
                                r_cnt       <= LP_CNT;
                                r_hreadyout <= 1'b0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write lands at the completing edge, so a read accepted on that edge sees it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_waddr][8*b +: 8] <= HWDATA[8*b +: 8];
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = (r_dp_valid && !r_dp_write) ? r_mem[w_waddr] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Randomised bench for ahb_sram_sub: three instances (0, 3 and 2 wait states)
// checked against a byte-addressed memory model.
module tb_ahb_sram_sub;
    localparam int NI = 3;

    logic        ACLK = 1'b0;
    logic        ARESET    [NI];
    logic        HSEL      [NI];
    logic [7:0]  HADDR     [NI];
    logic [1:0]  HTRANS    [NI];
    logic        HWRITE    [NI];
    logic [2:0]  HSIZE     [NI];
    logic [2:0]  HBURST    [NI];
    logic [31:0] HWDATA    [NI];
    logic        HREADY    [NI];
    logic        HREADYOUT [NI];
    logic        HRESP     [NI];
    logic [31:0] HRDATA    [NI];
    logic        hrdy_low  [NI];

    logic [7:0]  mb [NI][256];
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 ACLK = ~ACLK;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_sram_sub #(
            .ADDR_WIDTH (8),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .ACLK     (ACLK),
            .ARESET   (ARESET[g]),
            .HSEL     (HSEL[g]),
            .HADDR    (HADDR[g]),
            .HTRANS   (HTRANS[g]),
            .HWRITE   (HWRITE[g]),
            .HSIZE    (HSIZE[g]),
            .HBURST   (HBURST[g]),
            .HWDATA   (HWDATA[g]),
            .HREADY   (HREADY[g]),
            .HREADYOUT(HREADYOUT[g]),
            .HRESP    (HRESP[g]),
            .HRDATA   (HRDATA[g])
        );
        assign HREADY[g] = HREADYOUT[g] & ~hrdy_low[g];
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s act=%h exp=%h", tag, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mdl_rd(input int k, input logic [7:0] a);
        int base;
        base = int'(a) & 32'hFC;
        return {mb[k][base+3], mb[k][base+2], mb[k][base+1], mb[k][base]};
    endfunction

    // Each byte of the access takes the write-data lane matching its own address.
    task automatic mdl_wr(input int k, input logic [2:0] sz, input logic [7:0] a, input logic [31:0] wd);
        for (int b = 0; b < (1 << sz); b++) begin
            int ba;
            ba = int'(a) + b;
            mb[k][ba] = wd[8*(ba%4) +: 8];
        end
    endtask

    task automatic mdl_clr(input int k);
        for (int i = 0; i < 256; i++) mb[k][i] = 8'h00;
    endtask

    task automatic chk_rst(input int k);
        chk("rst_rdy",  32'(HREADYOUT[k]), 32'd1);
        chk("rst_resp", 32'(HRESP[k]),     32'd0);
        chk("rst_rd",   HRDATA[k],         32'd0);
    endtask

    task automatic xfer(input int k, input bit wr, input logic [2:0] sz, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
        bit          legal;
        bit          done;
        int          lows;
        logic [31:0] exp_rd;
        legal  = (sz < 3) && ((int'(a) % (1 << sz)) == 0);
        exp_rd = (legal && !wr) ? mdl_rd(k, a) : 32'd0;
        rd     = 32'd0;
        HSEL[k] = 1'b1; HADDR[k] = a; HTRANS[k] = 2'd2; HWRITE[k] = wr; HSIZE[k] = sz;
        HBURST[k] = 3'($urandom); HWDATA[k] = $urandom;
        @(posedge ACLK); #1;
        HTRANS[k] = 2'd0; HSEL[k] = 1'($urandom); HADDR[k] = 8'($urandom); HWDATA[k] = $urandom;
        done = 0; lows = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge ACLK);
            if (HREADYOUT[k]) begin
                done = 1;
                rd = HRDATA[k];
                HWDATA[k] = wd;
                chk("wait_n", 32'(lows), legal ? 32'(ws_of(k)) : 32'd1);
                chk("resp",   32'(HRESP[k]), legal ? 32'd0 : 32'd1);
                chk("rdata",  HRDATA[k], exp_rd);
            end else begin
                lows++;
                chk("low_resp", 32'(HRESP[k]), legal ? 32'd0 : 32'd1);
                if (!legal) chk("err1_rd", HRDATA[k], 32'd0);
                HWDATA[k] = $urandom;
            end
        end
        if (!done) chk("timeout", 32'(done), 32'd1);
        if (legal && wr) mdl_wr(k, sz, a, wd);
        @(posedge ACLK); #1;
    endtask

    // One cycle of traffic that must not start a data phase.
    task automatic idle_cycle(input int k, input int mode);
        HSEL[k]     = (mode != 0);
        HTRANS[k]   = (mode == 1) ? 2'd1 : ((mode == 2) ? 2'd0 : 2'd2);
        hrdy_low[k] = (mode == 3);
        HADDR[k] = 8'($urandom_range(0, 47)) & 8'hFC; HWRITE[k] = 1'b1; HSIZE[k] = 3'd2;
        HWDATA[k] = $urandom;
        @(posedge ACLK); #1;
        HTRANS[k] = 2'd0; HSEL[k] = 1'b0; hrdy_low[k] = 1'b0; HWDATA[k] = $urandom;
        @(negedge ACLK);
        chk("idle_rdy",  32'(HREADYOUT[k]), 32'd1);
        chk("idle_resp", 32'(HRESP[k]),     32'd0);
        chk("idle_rd",   HRDATA[k],         32'd0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [2:0]  sz;
        for (int k = 0; k < NI; k++) begin
            ARESET[k] = 1'b1; HSEL[k] = 1'b0; HADDR[k] = 8'h00; HTRANS[k] = 2'd0;
            HWRITE[k] = 1'b0; HSIZE[k] = 3'd0; HBURST[k] = 3'd0; HWDATA[k] = 32'd0;
            hrdy_low[k] = 1'b0;
            mdl_clr(k);
        end
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        for (int k = 0; k < NI; k++) chk_rst(k);
        @(posedge ACLK); #1;
        for (int k = 0; k < NI; k++) ARESET[k] = 1'b0;
        @(posedge ACLK); #1;

        // Zero-wait write followed directly by a read of the same word.
        HSEL[0] = 1'b1; HADDR[0] = 8'h10; HTRANS[0] = 2'd2; HWRITE[0] = 1'b1; HSIZE[0] = 3'd2;
        @(posedge ACLK); #1;
        HWRITE[0] = 1'b0; HWDATA[0] = 32'h11223344;
        @(negedge ACLK);
        chk("pipe_wr_rdy", 32'(HREADYOUT[0]), 32'd1);
        chk("pipe_wr_rd",  HRDATA[0], 32'd0);
        @(posedge ACLK); #1;
        HTRANS[0] = 2'd0; HSEL[0] = 1'b0; HWDATA[0] = $urandom;
        mdl_wr(0, 3'd2, 8'h10, 32'h11223344);
        @(negedge ACLK);
        chk("pipe_rd_rdy", 32'(HREADYOUT[0]), 32'd1);
        chk("pipe_rd",     HRDATA[0], 32'h11223344);
        @(posedge ACLK); #1;

        xfer(0, 1, 3'd2, 8'h20, 32'h0, rd);
        xfer(0, 1, 3'd0, 8'h21, 32'h0000AA00, rd);
        xfer(0, 1, 3'd1, 8'h22, 32'hBEEF0000, rd);
        xfer(0, 0, 3'd2, 8'h20, 32'h0, rd);
        chk("byte_half", rd, 32'hBEEFAA00);

        xfer(0, 1, 3'd2, 8'h04, 32'h5A5A1234, rd);
        xfer(0, 1, 3'd2, 8'h06, 32'hFFFFFFFF, rd);
        xfer(0, 0, 3'd2, 8'h04, 32'h0, rd);
        chk("misal_keep", rd, 32'h5A5A1234);

        xfer(1, 1, 3'd2, 8'h04, 32'h0BADCAFE, rd);
        xfer(1, 0, 3'd2, 8'h04, 32'h0, rd);
        chk("wait_rd", rd, 32'h0BADCAFE);

        xfer(0, 1, 3'd2, 8'h40, 32'h77778888, rd);
        for (int m = 0; m < 4; m++) idle_cycle(0, m);
        xfer(0, 0, 3'd2, 8'h40, 32'h0, rd);
        chk("desel_keep", rd, 32'h77778888);

        // Reset asserted during the first wait cycle of a write.
        xfer(2, 1, 3'd2, 8'h30, 32'hCAFEF00D, rd);
        HSEL[2] = 1'b1; HADDR[2] = 8'h30; HTRANS[2] = 2'd2; HWRITE[2] = 1'b1; HSIZE[2] = 3'd2;
        @(posedge ACLK); #1;
        HTRANS[2] = 2'd0; HSEL[2] = 1'b0; HWDATA[2] = 32'h12345678;
        chk("rw_wait", 32'(HREADYOUT[2]), 32'd0);
        ARESET[2] = 1'b1;
        #1;
        chk_rst(2);
        mdl_clr(2);
        @(posedge ACLK); #1;
        ARESET[2] = 1'b0;
        @(posedge ACLK); #1;
        xfer(2, 0, 3'd2, 8'h30, 32'h0, rd);
        chk("rst_word", rd, 32'd0);

        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 120; n++) begin
                if ($urandom_range(0, 9) == 0) begin
                    idle_cycle(k, int'($urandom_range(0, 3)));
                end else begin
                    sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                    xfer(k, 1'($urandom), sz, 8'($urandom_range(0, 47)), $urandom, rd);
                end
            end
            for (int w = 0; w < 48; w += 4) xfer(k, 0, 3'd2, 8'(w), 32'h0, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb_sram_sub.md
# ahb_sram_sub

AHB-Lite subordinate that responds to transfers issued by the AXI-to-AHB bridge's AHB manager port and backs them with a small on-chip word-organised register memory. It decodes address-phase controls, inserts a programmable number of wait states, and performs byte, halfword or word reads and writes. It returns the two-cycle ERROR response for illegal accesses. It sits on the AHB side of the bridge as the bench and default target for manager-side traffic.

## Interface
- `ADDR_WIDTH`, default 8: byte-address width. Memory depth = 2^(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, default 0: HREADYOUT-low cycles inserted per NONSEQ/SEQ transfer. Legal range 0..15.
- `ACLK`  in  1  clock; all state is on the rising edge.
- `ARESET`  in  1  reset, asynchronous, active-high.
- `HSEL`  in  1  subordinate select.
- `HADDR`  in  ADDR_WIDTH  byte address.
- `HTRANS`  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HWRITE`  in  1  1 = write.
- `HSIZE`  in  3  0 = byte, 1 = half, 2 = word; values ≥3 are illegal.
- `HBURST`  in  3  accepted and ignored; every beat carries its own address.
- `HWDATA`  in  32  write data, data phase.
- `HREADY`  in  1  bus-wide ready from the interconnect.
- `HREADYOUT`  out  1  this subordinate's ready.
- `HRESP`  out  1  0 = OKAY, 1 = ERROR.
- `HRDATA`  out  32  read data, valid when HREADYOUT=1 in a read data phase.

## Operation
- Accept condition: `HSEL && HREADY && HTRANS[1]` at a rising edge latches HADDR, HWRITE and HSIZE into the data-phase registers and starts a data phase.
- IDLE/BUSY, or HSEL=0, with HREADY=1: no data phase. HREADYOUT=1 and HRESP=0 in the following cycle.
- Illegal access is any of:
  - HSIZE ≥ 3;
  - HSIZE=1 with HADDR[0]≠0;
  - HSIZE=2 with HADDR[1:0]≠0.
- State machine states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted legal transfer, go to WAIT if WAIT_STATES>0; otherwise stay in IDLE and complete in the next cycle.
  - IDLE: on an accepted illegal transfer, go to ERR1.
  - WAIT: a wait counter loads WAIT_STATES-1 on entry and decrements each cycle. HREADYOUT=0 while in WAIT. When the count reaches 0, return to IDLE, and the next cycle is the completing cycle with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Go to IDLE. A new transfer may be accepted in this cycle and is decoded normally.
- Write commit: only in the completing cycle of a legal write data phase (HREADYOUT=1, HRESP=0).
  - Byte lanes are selected by the latched address [1:0] and size.
  - byte → lane addr[1:0]; half → lanes {addr[1],0} and {addr[1],1}; word → all four lanes.
  - Only the selected lanes of word `addr[ADDR_WIDTH-1:2]` update.
- Read: HRDATA = full memory word at the latched word address during a read data phase, and 0 otherwise. No lane masking is applied; the manager extracts the lanes it needs.
- Errored transfers never modify memory. HRDATA=0 during ERR1/ERR2.
- Back-to-back write then read of the same word returns the newly written data with no stall, because the write commits at the edge that starts the read's data phase.
- HWDATA is sampled only at the completing edge; its value during wait cycles is don't-care.

## Timing
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all memory words=0. ARESET mid-transfer aborts the transfer with no memory update.
- Data phase length is WAIT_STATES+1 cycles for a legal transfer and exactly 2 cycles for an error.
- Pipelining: with WAIT_STATES=0, a new transfer is accepted on every cycle, so N pipelined beats take N+1 cycles.
- HREADY held low by another subordinate: no transfer is accepted, and any latched data phase is unaffected.

## Test plan
- **Zero-wait word pipeline:** write 0x11223344 to 0x10, then read 0x10 back-to-back → HREADYOUT stays 1 and the read returns 0x11223344 one cycle after its address phase.
- **Byte and half writes:** word 0x20=0; write byte 0xAA at 0x21, then half 0xBEEF at 0x22 → read 0x20 returns 0xBEEFAA00.
- **Wait states:** WAIT_STATES=3, read 0x04 → HREADYOUT low for 3 cycles, then high with correct data on the 4th data-phase cycle.
- **Misaligned word write:** word write to 0x06 with HWDATA=0xFFFFFFFF → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); the next read of 0x04 is unchanged.
- **IDLE/BUSY and deselect:** HTRANS=BUSY, or HSEL=0 with NONSEQ → no memory change and HREADYOUT=1, HRESP=0.
- **Reset mid-wait:** WAIT_STATES=2 write, ARESET asserted in the first wait cycle → outputs return immediately to reset values and the target word reads 0 after reset.
